// File: rtl/branch_ctrl.sv
// Control-transfer unit: decodes jump/call/return strobes, drives the PC load
// pair with a one-cycle registered LOAD/FLUSH, and keeps a return-address stack.
module branch_ctrl #(
  parameter int STACK_DEPTH = 8,
  parameter int AW          = 16,
  localparam int PW         = $clog2(STACK_DEPTH),
  localparam int SPW        = PW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [AW-1:0] INSTR_PC,
  input  logic          JMP,
  input  logic          COND,
  input  logic          CALL,
  input  logic          RET,
  input  logic [AW-1:0] TARGET,
  input  logic          CLR_ERR,
  output logic          LOAD,
  output logic [AW-1:0] ADDRESS,
  output logic          FLUSH,
  output logic [SPW-1:0] SP,
  output logic          OVFL,
  output logic          UNDF
);

  localparam logic [SPW-1:0] FULL_SP = SPW'(STACK_DEPTH);

  logic          load_q, load_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic          ovfl_q, ovfl_d;
  logic          undf_q, undf_d;
  logic [AW-1:0] stack_q [STACK_DEPTH];

  logic          accept, do_ret, do_call, do_jmp, full, empty, push;
  logic [PW-1:0] push_idx, pop_idx;
  logic [SPW-1:0] sp_m1;

  // Strobes seen while LOAD is high belong to the squashed instruction.
  assign accept   = EN & ~load_q;
  assign do_ret   = accept & RET;
  assign do_call  = accept & CALL & ~RET;
  assign do_jmp   = accept & JMP & COND & ~RET & ~CALL;
  assign full     = (sp_q == FULL_SP);
  assign empty    = (sp_q == '0);
  assign sp_m1    = sp_q - SPW'(1);
  assign push_idx = sp_q[PW-1:0];
  assign pop_idx  = sp_m1[PW-1:0];

  always_comb begin
    load_d = 1'b0;
    addr_d = addr_q;
    sp_d   = sp_q;
    ovfl_d = ovfl_q & ~CLR_ERR;
    undf_d = undf_q & ~CLR_ERR;
    push   = 1'b0;
    if (do_ret) begin
      if (empty) begin
        undf_d = 1'b1;
      end else begin
        addr_d = stack_q[pop_idx];
        sp_d   = sp_m1;
        load_d = 1'b1;
      end
    end else if (do_call) begin
      // A full stack drops the push but the call still transfers control.
      if (full) begin
        ovfl_d = 1'b1;
      end else begin
        push = 1'b1;
        sp_d = sp_q + SPW'(1);
      end
      addr_d = TARGET;
      load_d = 1'b1;
    end else if (do_jmp) begin
      addr_d = TARGET;
      load_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_q <= 1'b0;
      addr_q <= '0;
      sp_q   <= '0;
      ovfl_q <= 1'b0;
      undf_q <= 1'b0;
    end else begin
      load_q <= load_d;
      addr_q <= addr_d;
      sp_q   <= sp_d;
      ovfl_q <= ovfl_d;
      undf_q <= undf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) stack_q[push_idx] <= INSTR_PC + AW'(1);
  end

  assign LOAD    = load_q;
  assign FLUSH   = load_q;
  assign ADDRESS = addr_q;
  assign SP      = sp_q;
  assign OVFL    = ovfl_q;
  assign UNDF    = undf_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: jumps, call/return, overflow/underflow,
// shadow-cycle and priority behaviour, async reset.
module tb_branch_ctrl;
  localparam int AW = 16;
  localparam int SD = 8;

  logic          CLK = 1'b0, RST = 1'b1, EN = 1'b0;
  logic [AW-1:0] INSTR_PC = '0, TARGET = '0;
  logic          JMP = 1'b0, COND = 1'b0, CALL = 1'b0, RET = 1'b0, CLR_ERR = 1'b0;
  logic          LOAD, FLUSH, OVFL, UNDF;
  logic [AW-1:0] ADDRESS;
  logic [3:0]    SP;

  int vectors = 0;
  int miscompares = 0;

  branch_ctrl #(.STACK_DEPTH(SD), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .INSTR_PC(INSTR_PC), .JMP(JMP), .COND(COND),
    .CALL(CALL), .RET(RET), .TARGET(TARGET), .CLR_ERR(CLR_ERR),
    .LOAD(LOAD), .ADDRESS(ADDRESS), .FLUSH(FLUSH), .SP(SP), .OVFL(OVFL), .UNDF(UNDF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    EN = 1'b0; JMP = 1'b0; COND = 1'b0; CALL = 1'b0; RET = 1'b0; CLR_ERR = 1'b0;
  endtask

  task automatic req(input logic j, input logic c, input logic cl, input logic r,
                     input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
    EN = 1'b1; JMP = j; COND = c; CALL = cl; RET = r; INSTR_PC = pc; TARGET = tgt;
  endtask

  initial begin
    #12;
    chk("rst_load", LOAD, 0);  chk("rst_flush", FLUSH, 0); chk("rst_addr", ADDRESS, 0);
    chk("rst_sp", SP, 0);      chk("rst_ovfl", OVFL, 0);   chk("rst_undf", UNDF, 0);
    @(posedge CLK); #1 RST = 1'b0;
    cyc(); chk("idle_load", LOAD, 0);

    // conditional jump taken, then held
    req(1, 1, 0, 0, 16'h0000, 16'h1234); cyc(); idle();
    chk("jmp_load", LOAD, 1); chk("jmp_flush", FLUSH, 1); chk("jmp_addr", ADDRESS, 16'h1234);
    cyc();
    chk("jmp_load_off", LOAD, 0); chk("jmp_flush_off", FLUSH, 0); chk("jmp_hold", ADDRESS, 16'h1234);

    // condition false
    req(1, 0, 0, 0, 16'h0000, 16'h5555); cyc(); idle();
    chk("jnt_load", LOAD, 0); chk("jnt_addr", ADDRESS, 16'h1234);

    // call, shadowed RET, then real RET
    req(0, 0, 1, 0, 16'h0040, 16'h0200); cyc();
    chk("call_load", LOAD, 1); chk("call_addr", ADDRESS, 16'h0200); chk("call_sp", SP, 1);
    req(0, 0, 0, 1, 16'h0201, 16'h0000); cyc();
    chk("shadow_load", LOAD, 0); chk("shadow_sp", SP, 1);
    cyc(); idle();
    chk("ret_load", LOAD, 1); chk("ret_addr", ADDRESS, 16'h0041); chk("ret_sp", SP, 0);
    cyc();

    // underflow and clear, plus set-beats-clear
    req(0, 0, 0, 1, 16'h0050, 16'h0000); cyc(); idle();
    chk("undf_load", LOAD, 0); chk("undf_flag", UNDF, 1); chk("undf_addr", ADDRESS, 16'h0041);
    CLR_ERR = 1'b1; cyc(); CLR_ERR = 1'b0;
    chk("undf_clr", UNDF, 0);
    req(0, 0, 0, 1, 16'h0050, 16'h0000); CLR_ERR = 1'b1; cyc(); idle();
    chk("undf_set_wins", UNDF, 1);
    CLR_ERR = 1'b1; cyc(); CLR_ERR = 1'b0;
    chk("undf_clr2", UNDF, 0);

    // priority RET > CALL > JMP
    req(0, 0, 1, 0, 16'h0100, 16'h0300); cyc(); idle();
    chk("pri_call_sp", SP, 1);
    cyc();
    req(1, 1, 1, 1, 16'h0500, 16'h0600); cyc(); idle();
    chk("pri_load", LOAD, 1); chk("pri_addr", ADDRESS, 16'h0101); chk("pri_sp", SP, 0);
    cyc();

    // return address wraps
    req(0, 0, 1, 0, 16'hFFFF, 16'h0010); cyc(); idle();
    chk("wrap_call_addr", ADDRESS, 16'h0010); chk("wrap_call_sp", SP, 1);
    cyc();
    req(0, 0, 0, 1, 16'h0010, 16'h0000); cyc(); idle();
    chk("wrap_ret_addr", ADDRESS, 16'h0000); chk("wrap_ret_sp", SP, 0);
    cyc();

    // overflow: 9 calls, 8 returns
    for (int i = 0; i < 9; i++) begin
      req(0, 0, 1, 0, AW'(16'h0010 + i), AW'(16'h0800 + i)); cyc(); idle();
      chk($sformatf("ovf_call%0d_load", i), LOAD, 1);
      chk($sformatf("ovf_call%0d_addr", i), ADDRESS, 16'h0800 + i);
      chk($sformatf("ovf_call%0d_sp", i), SP, (i < 8) ? i + 1 : 8);
      chk($sformatf("ovf_call%0d_flag", i), OVFL, (i == 8) ? 1 : 0);
      cyc();
    end
    for (int k = 0; k < 8; k++) begin
      req(0, 0, 0, 1, 16'h0900, 16'h0000); cyc(); idle();
      chk($sformatf("ovf_ret%0d_addr", k), ADDRESS, 16'h0018 - k);
      chk($sformatf("ovf_ret%0d_sp", k), SP, 7 - k);
      cyc();
    end
    chk("ovfl_sticky", OVFL, 1);

    // async reset mid-transfer
    req(0, 0, 1, 0, 16'h0020, 16'hABCD); cyc(); idle();
    chk("pre_rst_load", LOAD, 1); chk("pre_rst_sp", SP, 1);
    #3 RST = 1'b1;
    #1;
    chk("arst_load", LOAD, 0);  chk("arst_flush", FLUSH, 0); chk("arst_addr", ADDRESS, 0);
    chk("arst_sp", SP, 0);      chk("arst_ovfl", OVFL, 0);   chk("arst_undf", UNDF, 0);
    @(posedge CLK); #1 RST = 1'b0;
    cyc(); chk("post_rst_load", LOAD, 0);
    cyc(); chk("post_rst_load2", LOAD, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-transfer unit that drives the PC's LOAD/ADDRESS pair. It decodes jump, call and return strobes from the instruction decoder and keeps a hardware return-address stack.
- Issues a one-cycle registered load request plus a FLUSH so the core discards the instruction fetched under the stale PC.
- Sits between the decoder and the PC; it is the only source of PC loads.

Parameters:
- STACK_DEPTH, 8, number of return-address entries (power of two, ≥2).
- AW, 16, address width; matches the PC width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  decoder strobes valid this cycle.
- INSTR_PC  in  AW  address of the instruction currently being decoded.
- JMP  in  1  jump request; taken only if COND=1.
- COND  in  1  branch condition (1 = taken); use 1 for unconditional jumps.
- CALL  in  1  call request (unconditional).
- RET  in  1  return request (unconditional).
- TARGET  in  AW  destination for JMP/CALL.
- CLR_ERR  in  1  clears the sticky error flags.
- LOAD  out  1  registered; PC loads ADDRESS on the next edge.
- ADDRESS  out  AW  registered load address.
- FLUSH  out  1  registered; high in the same cycle as LOAD; squash the current fetch.
- SP  out  log2(STACK_DEPTH)+1  current stack occupancy, 0..STACK_DEPTH.
- OVFL  out  1  sticky; a push was attempted while full.
- UNDF  out  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (async, on assertion): LOAD=0, ADDRESS=0, FLUSH=0, SP=0, OVFL=0, UNDF=0. Stack RAM contents are not reset.
- Requests are sampled on the rising CLK edge when EN=1 and LOAD=0.
- Shadow cycle: while LOAD=1, the decoder strobes belong to a squashed instruction and are ignored entirely. This means no stack change and no flag change.
- Priority when several strobes are high: RET > CALL > JMP. Lower-priority strobes in that cycle are ignored.
- Each accepted transfer produces exactly one cycle of LOAD=1 and FLUSH=1, starting the cycle after the request edge. Both return to 0 on the following edge.
- ADDRESS holds its last value when LOAD=0.
- JMP with COND=1: ADDRESS←TARGET, LOAD←1.
- JMP with COND=0: no action; LOAD stays 0.
- CALL, stack not full: stack[SP]←INSTR_PC+1, computed modulo 2^AW so 0xFFFF+1 wraps to 0x0000. Then SP←SP+1, ADDRESS←TARGET, LOAD←1.
- CALL, stack full (SP=STACK_DEPTH): the push is dropped and existing entries are kept. OVFL←1, SP unchanged, and the jump is still taken (ADDRESS←TARGET, LOAD←1).
- RET, SP>0: ADDRESS←stack[SP-1], SP←SP-1, LOAD←1.
- RET, SP=0: UNDF←1, LOAD stays 0, and execution falls through.
- CLR_ERR=1 at an edge clears OVFL and UNDF. A same-edge set takes priority over the clear.
- Latency from request edge to PC holding the new value is 2 edges: request→LOAD, then LOAD→PC.
- Reset mid-transfer: LOAD and FLUSH drop immediately on reset assertion. The pending transfer is lost and SP returns to 0.

Test Plan:
- Reset: assert RST mid-cycle → LOAD=0, FLUSH=0, ADDRESS=0, SP=0, OVFL=0, UNDF=0 without waiting for a clock edge. After release, no LOAD until a request arrives.
- Conditional jump:
  - JMP=1, COND=1, TARGET=0x1234 → next cycle LOAD=1, FLUSH=1, ADDRESS=0x1234 for exactly one cycle.
  - Same request with COND=0 → LOAD stays 0.
- Call/return round trip:
  - CALL at INSTR_PC=0x0040, TARGET=0x0200 → ADDRESS=0x0200, SP=1.
  - Two cycles later, RET → ADDRESS=0x0041, SP=0.
- Overflow: 9 CALLs at INSTR_PC=0x10..0x18 with STACK_DEPTH=8 → 9th sets OVFL=1, SP stays 8. Eight RETs then return 0x18..0x11 in order.
- Underflow: RET with SP=0 → UNDF=1, no LOAD. CLR_ERR → UNDF=0.
- Shadow/priority:
  - CALL immediately followed next cycle (LOAD=1) by RET → RET ignored, SP=1.
  - RET and CALL together with SP=1 → RET wins, SP=0.
  - CALL at INSTR_PC=0xFFFF → pushed value 0x0000.
